instr_fetch: RTL

//  Instruction fetch stage, directly upstream of the decode controller.
//  - Holds the program counter and reads instruction memory (fixed 1-cycle read latency).
//  - Buffers fetched words in a small FIFO; presents the head as instr/valid.
//  - Pops on the controller's next_instr.
//  - Redirects to jdata on jump, discarding everything fetched on the old path.

---
 rtl/instr_fetch.sv | 101 ++++++++++
 1 files changed

// File: rtl/instr_fetch.sv
// Instruction fetch stage: PC, fixed 1-cycle imem read, credit-controlled
// prefetch FIFO feeding decode, and jump redirect with full flush.
module instr_fetch #(
  parameter int unsigned WIDTH_INSTR = 16,
  parameter int unsigned WIDTH_JDATA = 24,
  parameter int unsigned DEPTH_FIFO  = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   run,
  output logic                   imem_en,
  output logic [WIDTH_JDATA-1:0] imem_addr,
  input  logic [WIDTH_INSTR-1:0] imem_rdata,
  output logic [WIDTH_INSTR-1:0] instr,
  output logic                   valid,
  input  logic                   next_instr,
  input  logic                   jump,
  input  logic [WIDTH_JDATA-1:0] jdata
);

  localparam int unsigned PTR_W = (DEPTH_FIFO > 1) ? $clog2(DEPTH_FIFO) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned SUM_W = CNT_W + 1;

  logic [WIDTH_JDATA-1:0] pc_q, pc_d;
  logic                   pending_q, pending_d;
  logic [CNT_W-1:0]       count_q, count_d;
  logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
  logic [WIDTH_INSTR-1:0] fifo_q [DEPTH_FIFO];
  logic [WIDTH_INSTR-1:0] fifo_d [DEPTH_FIFO];

  logic issue_c;
  logic credit_ok_c;
  logic push_c;
  logic pop_c;

  // Outstanding reads count against FIFO space so a return always has a slot.
  always_comb begin
    credit_ok_c = ({1'b0, count_q} + SUM_W'(pending_q)) < SUM_W'(DEPTH_FIFO);
    issue_c     = run & ~jump & credit_ok_c;
    push_c      = pending_q & ~jump;
    pop_c       = next_instr & valid & ~jump;
  end

  // Reset also masks the strobe so no read is requested while held in reset.
  assign imem_en   = rst_n & issue_c;
  assign imem_addr = pc_q;
  assign valid     = (count_q != '0);
  assign instr     = valid ? fifo_q[rd_ptr_q] : '0;

  always_comb begin
    pc_d      = pc_q;
    pending_d = pending_q;
    count_d   = count_q;
    rd_ptr_d  = rd_ptr_q;
    wr_ptr_d  = wr_ptr_q;
    fifo_d    = fifo_q;
    if (jump) begin
      pc_d      = jdata;
      pending_d = 1'b0;
      count_d   = '0;
      rd_ptr_d  = '0;
      wr_ptr_d  = '0;
    end else begin
      pending_d = issue_c;
      if (issue_c) begin
        pc_d = pc_q + WIDTH_JDATA'(1);
      end
      if (push_c) begin
        fifo_d[wr_ptr_q] = imem_rdata;
        wr_ptr_d         = wr_ptr_q + PTR_W'(1);
      end
      if (pop_c) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      count_d = count_q + CNT_W'(push_c) - CNT_W'(pop_c);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q      <= '0;
      pending_q <= 1'b0;
      count_q   <= '0;
      rd_ptr_q  <= '0;
      wr_ptr_q  <= '0;
      for (int i = 0; i < int'(DEPTH_FIFO); i++) begin
        fifo_q[i] <= '0;
      end
    end else begin
      pc_q      <= pc_d;
      pending_q <= pending_d;
      count_q   <= count_d;
      rd_ptr_q  <= rd_ptr_d;
      wr_ptr_q  <= wr_ptr_d;
      fifo_q    <= fifo_d;
    end
  end

endmodule
